// File: rtl/fetch_pkg.sv
// Shared definitions for the two-byte instruction fetch controller.
package fetch_pkg;

    localparam int unsigned INSTR_W          = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        CAPTURE  = 2'd2,
        HOLD     = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: redirects to a halfword-aligned target or advances by one
// instruction (two bytes), wrapping at the top of the address space.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // NOTE: combinational blocks assign a default first so no path leaves pc_d unassigned (no latch).
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & ~ADDR_W'(1);
        end else if (advance_i) begin
            pc_d = pc_q + ADDR_W'(2);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetches big-endian 16-bit instructions from a byte-wide synchronous memory
// in two reads, then holds the result until decode accepts it.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               FetchEn,
    input  logic               BranchValid,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic               MemEn,
    output logic [ADDR_W-1:0]  MemAddr,
    input  logic [7:0]         MemData,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady
);

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic [7:0]         hi_byte_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               valid_q;
    logic [ADDR_W-1:0]  pc;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (Clock),
        .rst_n      (ResetN),
        .redirect_i (BranchValid),
        .target_i   (BranchTarget),
        .advance_i  (state_q == CAPTURE),
        .pc_o       (pc)
    );

    // A redirect overrides every other transition, abandoning any partial fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_HI: if (FetchEn) state_d = FETCH_LO;
            FETCH_LO: state_d = CAPTURE;
            CAPTURE:  state_d = HOLD;
            HOLD:     if (InstrReady) state_d = FETCH_HI;
            default:  state_d = FETCH_HI;
        endcase
        if (BranchValid) begin
            state_d = FETCH_HI;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= FETCH_HI;
            hi_byte_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH_LO) begin
                hi_byte_q <= MemData;
            end
            if (BranchValid) begin
                valid_q <= 1'b0;
            end else if (state_q == CAPTURE) begin
                instr_q    <= {hi_byte_q, MemData};
                instr_pc_q <= pc;
                valid_q    <= 1'b1;
            end else if (state_q == HOLD && InstrReady) begin
                valid_q <= 1'b0;
            end
        end
    end

    // The strobe is gated by reset because the reset state itself issues reads.
    assign MemEn       = ResetN && ((state_q == FETCH_HI && FetchEn) || state_q == FETCH_LO);
    assign MemAddr     = (state_q == FETCH_LO) ? pc + ADDR_W'(1) : pc;
    assign Instruction = instr_q;
    assign InstrPC     = instr_pc_q;
    assign InstrValid  = valid_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against an instruction-stream reference model.
module tb_fetch_controller;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        Clock;
    logic        ResetN;
    logic        FetchEn;
    logic        BranchValid;
    logic [15:0] BranchTarget;
    logic        MemEn;
    logic [15:0] MemAddr;
    logic [7:0]  MemData;
    logic [15:0] Instruction;
    logic [15:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;

    logic [7:0] mem [0:65535];
    int n_tests;
    int n_fail;

    fetch_controller dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .FetchEn      (FetchEn),
        .BranchValid  (BranchValid),
        .BranchTarget (BranchTarget),
        .MemEn        (MemEn),
        .MemAddr      (MemAddr),
        .MemData      (MemData),
        .Instruction  (Instruction),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Byte-wide synchronous memory: data appears the cycle after the strobe.
    initial MemData = 8'h00;
    always @(posedge Clock) begin
        if (MemEn) MemData <= mem[MemAddr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench did not terminate");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] addr);
        logic [15:0] next_addr;
        next_addr = addr + 16'd1;
        return {mem[addr], mem[next_addr]};
    endfunction

    task automatic do_reset(input string tag);
        ResetN = 1'b0;
        #2;
        check({tag, "_memen"}, MemEn, 0);
        check({tag, "_valid"}, InstrValid, 0);
        check({tag, "_instr"}, Instruction, 0);
        check({tag, "_ipc"}, InstrPC, 0);
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        #1;
    endtask

    initial begin
        int          gap;
        int          n_delivered;
        logic [15:0] exp_pc;
        logic [15:0] exp_lo;
        logic        in_lo;
        logic        prev_valid, prev_ready, prev_branch, prev_memen;
        logic [15:0] prev_target, prev_instr, prev_pc;

        n_tests = 0;
        n_fail  = 0;
        ResetN       = 1'b0;
        FetchEn      = 1'b1;
        BranchValid  = 1'b0;
        BranchTarget = 16'h0000;
        InstrReady   = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[16'h0040] = 8'hAB; mem[16'h0041] = 8'hCD;

        // Back-to-back fetch with decode always ready.
        do_reset("t1_rst");
        check("t1_hi_en", MemEn, 1);
        check("t1_hi_addr", MemAddr, RESET_PC);
        tick();
        check("t1_lo_en", MemEn, 1);
        check("t1_lo_addr", MemAddr, 16'h0001);
        tick();
        check("t1_cap_en", MemEn, 0);
        check("t1_cap_valid", InstrValid, 0);
        tick();
        check("t1_valid0", InstrValid, 1);
        check("t1_instr0", Instruction, 16'h1234);
        check("t1_ipc0", InstrPC, 16'h0000);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!InstrValid && gap < 20);
        check("t1_gap", gap, 4);
        check("t1_instr1", Instruction, 16'h5678);
        check("t1_ipc1", InstrPC, 16'h0002);

        // Decode stalls for five cycles.
        InstrReady = 1'b0;
        do_reset("t2_rst");
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", InstrValid, 1);
            check("t2_instr", Instruction, 16'h1234);
            check("t2_memen", MemEn, 0);
            tick();
        end
        InstrReady = 1'b1;
        #1;
        check("t2_still_valid", InstrValid, 1);
        tick();
        check("t2_released", InstrValid, 0);
        check("t2_next_addr", MemAddr, 16'h0002);

        // Redirect during the low-byte read.
        do_reset("t3_rst");
        tick();
        BranchValid  = 1'b1;
        BranchTarget = 16'h0041;
        #1;
        check("t3_lo_valid", InstrValid, 0);
        tick();
        BranchValid = 1'b0;
        #1;
        check("t3_hi_valid", InstrValid, 0);
        check("t3_hi_en", MemEn, 1);
        check("t3_hi_addr", MemAddr, 16'h0040);
        tick();
        check("t3_lo_addr", MemAddr, 16'h0041);
        tick(); tick();
        check("t3_valid", InstrValid, 1);
        check("t3_ipc", InstrPC, 16'h0040);
        check("t3_instr", Instruction, 16'hABCD);

        // Fetch straddling the top of the address space.
        do_reset("t4_rst");
        FetchEn      = 1'b0;
        BranchValid  = 1'b1;
        BranchTarget = 16'hFFFE;
        #1;
        check("t4_gate", MemEn, 0);
        tick();
        BranchValid = 1'b0;
        FetchEn     = 1'b1;
        #1;
        check("t4_hi_addr", MemAddr, 16'hFFFE);
        tick();
        check("t4_lo_addr", MemAddr, 16'hFFFF);
        tick(); tick();
        check("t4_valid", InstrValid, 1);
        check("t4_ipc", InstrPC, 16'hFFFE);
        check("t4_instr", Instruction, word_at(16'hFFFE));
        tick();
        check("t4_wrap_en", MemEn, 1);
        check("t4_wrap_addr", MemAddr, 16'h0000);

        // Reset pulses during CAPTURE and during HOLD.
        do_reset("t5_rst");
        tick(); tick();
        check("t5_cap_en", MemEn, 0);
        do_reset("t5_cap");
        check("t5_cap_addr", MemAddr, RESET_PC);
        check("t5_cap_en2", MemEn, 1);
        InstrReady = 1'b0;
        tick(); tick(); tick();
        check("t5_hold_valid", InstrValid, 1);
        do_reset("t5_hold");
        check("t5_hold_addr", MemAddr, RESET_PC);
        InstrReady = 1'b1;

        // Fetch held off after reset.
        FetchEn = 1'b0;
        do_reset("t6_rst");
        for (int i = 0; i < 3; i++) begin
            check("t6_idle_en", MemEn, 0);
            tick();
        end
        FetchEn = 1'b1;
        #1;
        check("t6_start_en", MemEn, 1);
        check("t6_start_addr", MemAddr, 16'h0000);
        tick(); tick(); tick();
        check("t6_valid", InstrValid, 1);
        check("t6_instr", Instruction, 16'h1234);

        // Randomized traffic against an instruction-stream model.
        do_reset("rnd_rst");
        exp_pc      = RESET_PC;
        n_delivered = 0;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        prev_branch = 1'b0;
        prev_memen  = 1'b0;
        prev_target = 16'h0000;
        prev_instr  = 16'h0000;
        prev_pc     = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            FetchEn      = ($urandom_range(0, 9) < 8);
            InstrReady   = ($urandom_range(0, 9) < 6);
            BranchValid  = ($urandom_range(0, 19) == 0);
            BranchTarget = 16'($urandom);
            #1;
            if (prev_branch) exp_pc = {prev_target[15:1], 1'b0};
            if (prev_valid && prev_ready) begin
                check("rnd_hs_clear", InstrValid, 0);
            end else if (prev_valid && !prev_branch) begin
                check("rnd_hold_valid", InstrValid, 1);
                check("rnd_hold_instr", Instruction, prev_instr);
                check("rnd_hold_ipc", InstrPC, prev_pc);
            end
            if (InstrValid && !prev_valid) begin
                check("rnd_ipc", InstrPC, exp_pc);
                check("rnd_instr", Instruction, word_at(exp_pc));
                exp_pc = exp_pc + 16'd2;
                n_delivered++;
            end
            if (InstrValid) check("rnd_memen_valid", MemEn, 0);
            in_lo  = prev_memen && !prev_branch;
            exp_lo = exp_pc + 16'd1;
            if (MemEn) check("rnd_addr", MemAddr, in_lo ? exp_lo : exp_pc);
            if (!FetchEn && !in_lo) check("rnd_fetchen_gate", MemEn, 0);
            prev_valid  = InstrValid;
            prev_ready  = InstrReady;
            prev_branch = BranchValid;
            prev_target = BranchTarget;
            prev_memen  = MemEn;
            prev_instr  = Instruction;
            prev_pc     = InstrPC;
            tick();
        end
        check("rnd_delivered_min", n_delivered >= 50, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
